// File: rtl/echo_delay_proc_pkg.sv
// Shared constants, state encoding and helpers for the echo/delay processor.
package echo_pkg;

    // Default converter offsets for the 10-bit ADC/DAC pair
    localparam logic [9:0] ADC_OFFSET_DEF = 10'h181;
    localparam logic [9:0] DAC_OFFSET_DEF = 10'h200;

    // Buffer content selection
    localparam logic MODE_FF = 1'b0;   // buffer stores input x
    localparam logic MODE_FB = 1'b1;   // buffer stores output y

    // FILL masks buffer contents until delay_len samples have been written
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Clamp a signed value to the range of a w-bit two's complement number
    function automatic logic signed [31:0] saturate(input logic signed [31:0] s,
                                                    input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (s > hi)      return hi;
        else if (s < lo) return lo;
        else             return s;
    endfunction

endpackage

// File: rtl/echo_delay_proc_if.sv
// Sample stream and control bundle between the capture/playback logic and the echo core.
interface echo_delay_proc_if
    import echo_pkg::*;
#(
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned MAX_DELAY = 1024
);
    localparam int unsigned ADDR_W = clog2(MAX_DELAY);

    logic              pulse;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic [ADDR_W-1:0] delay_len;
    logic [2:0]        gain_shift;
    logic              mode;
    logic              sat;
    logic              overrun;

    modport master (
        output pulse, data_in, delay_len, gain_shift, mode,
        input  data_out, out_valid, sat, overrun
    );

    modport slave (
        input  pulse, data_in, delay_len, gain_shift, mode,
        output data_out, out_valid, sat, overrun
    );

endinterface

// File: rtl/echo_delay_proc_ram.sv
// Simple dual-port delay-line RAM: one write port, one synchronous read port.
module echo_ram #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and registered read; contents are never cleared
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/echo_delay_proc.sv
// Echo/delay processor: offset removal, delayed-sample mix, saturation, DAC re-offset.
module echo_delay_proc
    import echo_pkg::*;
#(
    parameter int unsigned       DATA_W     = 10,
    parameter int unsigned       MAX_DELAY  = 1024,
    parameter logic [DATA_W-1:0] ADC_OFFSET = DATA_W'(ADC_OFFSET_DEF),
    parameter logic [DATA_W-1:0] DAC_OFFSET = DATA_W'(DAC_OFFSET_DEF)
) (
    input  logic             sysclk,
    input  logic             rst_n,
    echo_delay_proc_if.slave bus
);

    localparam int unsigned ADDR_W = clog2(MAX_DELAY);

    state_t                    state;
    logic [ADDR_W-1:0]         wp;
    logic [ADDR_W-1:0]         fill_cnt;
    logic [ADDR_W-1:0]         fill_nx;
    logic [ADDR_W-1:0]         dl_q;
    logic [ADDR_W-1:0]         ra;
    logic [2:0]                gs_q;
    logic                      mode_q;
    logic                      s1_valid;
    logic                      busy;
    logic                      accept;
    logic signed [DATA_W-1:0]  x_q;
    logic [DATA_W-1:0]         rd_data;
    logic signed [DATA_W-1:0]  d;
    logic signed [DATA_W-1:0]  z;
    logic signed [DATA_W:0]    s;
    logic signed [31:0]        s_ext;
    logic signed [31:0]        sat_ext;
    logic signed [DATA_W-1:0]  y;
    logic                      clip;
    logic [DATA_W-1:0]         wr_data;
    logic [DATA_W-1:0]         data_out_q;
    logic                      out_valid_q;
    logic                      sat_q;
    logic                      overrun_q;

    // A sample occupies the pipeline for the read cycle and the output cycle
    assign busy   = s1_valid | out_valid_q;
    assign accept = bus.pulse & ~busy;
    assign ra     = wp - bus.delay_len;

    echo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_DELAY),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (sysclk),
        .we    (s1_valid),
        .waddr (wp),
        .wdata (wr_data),
        .re    (accept),
        .raddr (ra),
        .rdata (rd_data)
    );

    // Mix stage: masked delayed term, attenuation, widened sum and clamp
    always_comb begin
        d       = (state == RUN) ? rd_data : '0;
        z       = d >>> gs_q;
        s       = {x_q[DATA_W-1], x_q} + {z[DATA_W-1], z};
        s_ext   = 32'(s);
        sat_ext = saturate(s_ext, DATA_W);
        y       = sat_ext[DATA_W-1:0];
        clip    = (sat_ext != s_ext);
        wr_data = (mode_q == MODE_FB) ? y : x_q;
        fill_nx = (fill_cnt < dl_q) ? fill_cnt + ADDR_W'(1) : fill_cnt;
    end

    // Sample pipeline, fill/run state machine and registered outputs
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            wp          <= '0;
            fill_cnt    <= '0;
            dl_q        <= '0;
            gs_q        <= '0;
            mode_q      <= MODE_FF;
            x_q         <= '0;
            s1_valid    <= 1'b0;
            data_out_q  <= DAC_OFFSET;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            s1_valid    <= accept;
            if (bus.pulse && busy) overrun_q <= 1'b1;
            if (accept) begin
                x_q    <= bus.data_in - ADC_OFFSET;
                dl_q   <= bus.delay_len;
                gs_q   <= bus.gain_shift;
                mode_q <= bus.mode;
                // A new delay invalidates the history; refill before echoing
                if (bus.delay_len != dl_q) begin
                    fill_cnt <= '0;
                    state    <= FILL;
                end
            end
            if (s1_valid) begin
                wp          <= wp + ADDR_W'(1);
                fill_cnt    <= fill_nx;
                state       <= (dl_q != '0 && fill_nx >= dl_q) ? RUN : FILL;
                data_out_q  <= y + DAC_OFFSET;
                out_valid_q <= 1'b1;
                sat_q       <= clip;
            end
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sat       = sat_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_echo_delay_proc.sv
// Scoreboard bench for echo_delay_proc with a 16-deep buffer to exercise pointer wrap.
module tb_echo_delay_proc;

    localparam int unsigned DW = 10;
    localparam int unsigned MD = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sat;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    echo_delay_proc_if #(.DATA_W(DW), .MAX_DELAY(MD)) bus ();

    echo_delay_proc #(.DATA_W(DW), .MAX_DELAY(MD)) dut (
        .sysclk (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every out_valid must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got 0x%0h expected none at %0t", bus.data_out, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("data_out", int'(bus.data_out), int'(e.data));
                check("sat", int'(bus.sat), int'(e.sat));
            end
        end
    end

    task automatic set_cfg(input int dl, input int gs, input logic m);
        bus.delay_len  = 4'(dl);
        bus.gain_shift = 3'(gs);
        bus.mode       = m;
    endtask

    // One-cycle pulse; returns so that the next call lands exactly 3 cycles later
    task automatic send(input int din, input int exp_out, input logic exp_sat);
        exp_t e;
        @(posedge clk); #1;
        bus.pulse   = 1'b1;
        bus.data_in = 10'(din);
        e.data = 10'(exp_out);
        e.sat  = exp_sat;
        q.push_back(e);
        @(posedge clk); #1;
        bus.pulse = 1'b0;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("rst_data_out", int'(bus.data_out), 'h200);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_sat", int'(bus.sat), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
    endtask

    function automatic int t3_exp(input int i);
        case (i)
            0:       return 'h19C;
            4:       return 'h1CE;
            8:       return 'h1E7;
            12:      return 'h1F3;
            16:      return 'h1F9;
            20:      return 'h1FC;
            24:      return 'h1FE;
            28, 32:  return 'h1FF;
            default: return 'h200;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_v;
        rst_n        = 1'b0;
        bus.pulse    = 1'b0;
        bus.data_in  = 10'h181;
        set_cfg(4, 1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-stream: an in-flight sample is dropped, then 2-cycle latency
        send('h1E5, 'h264, 1'b0);
        send('h181, 'h200, 1'b0);
        @(posedge clk); #1;
        bus.pulse = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("mid_rst_data_out", int'(bus.data_out), 'h200);
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_overrun", int'(bus.overrun), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.pulse = 1'b0;
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        bus.pulse   = 1'b1;
        bus.data_in = 10'h181;
        q.push_back(exp_t'({10'h200, 1'b0}));
        @(posedge clk); #1;
        bus.pulse = 1'b0;
        check("lat_n1_out_valid", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        check("lat_n2_out_valid", int'(bus.out_valid), 1);
        repeat (2) @(posedge clk);

        // Feed-forward single echo, half gain
        do_reset();
        set_cfg(4, 1, 1'b0);
        send('h1E5, 'h264, 1'b0);
        for (int i = 1; i < 10; i++) send('h181, (i == 4) ? 'h232 : 'h200, 1'b0);

        // Feedback recursive echo, floor rounding of negative values
        do_reset();
        set_cfg(4, 1, 1'b1);
        for (int i = 0; i < 36; i++) send((i == 0) ? 'h11D : 'h181, t3_exp(i), 1'b0);

        // Positive saturation
        do_reset();
        set_cfg(2, 0, 1'b0);
        for (int i = 0; i < 5; i++) send('h375, (i < 2) ? 'h3F4 : 'h3FF, i >= 2);

        // Negative saturation
        do_reset();
        set_cfg(2, 0, 1'b0);
        for (int i = 0; i < 5; i++) send('h38D, (i < 2) ? 'h00C : 'h000, i >= 2);

        // delay_len = 0 means no echo at all
        do_reset();
        set_cfg(0, 0, 1'b0);
        for (int i = 0; i < 5; i++) send('h18B, 'h20A, 1'b0);

        // Ramp across pointer wrap, then a delay change forces a refill
        do_reset();
        set_cfg(15, 0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            exp_v = (k < 15) ? k : 2 * k - 15;
            send('h181 + k, 'h200 + exp_v, 1'b0);
        end
        set_cfg(3, 0, 1'b0);
        for (int k = 40; k < 46; k++) begin
            exp_v = (k < 43) ? k : 2 * k - 3;
            send('h181 + k, 'h200 + exp_v, 1'b0);
        end

        // Overrun: pulses at N+1 and N+2 are dropped, flag is sticky
        do_reset();
        set_cfg(4, 1, 1'b0);
        @(posedge clk); #1;
        bus.pulse   = 1'b1;
        bus.data_in = 10'h1E5;
        q.push_back(exp_t'({10'h264, 1'b0}));
        @(posedge clk); #1;
        bus.data_in = 10'h375;
        @(posedge clk); #1;
        bus.pulse = 1'b0;
        check("overrun_n1", int'(bus.overrun), 1);
        repeat (3) @(posedge clk);
        #1;
        bus.pulse   = 1'b1;
        bus.data_in = 10'h181;
        q.push_back(exp_t'({10'h200, 1'b0}));
        @(posedge clk); #1;
        bus.pulse = 1'b0;
        @(posedge clk); #1;
        bus.pulse   = 1'b1;
        bus.data_in = 10'h375;
        @(posedge clk); #1;
        bus.pulse = 1'b0;
        repeat (3) @(posedge clk);
        send('h181, 'h200, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("overrun_held", int'(bus.overrun), 1);
        do_reset();

        // Drain: every expectation must have been consumed
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        check("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
